// File: rtl/eth_txc_pkg.sv
// Shared types and constants for the Ethernet TX control-word framer.
`timescale 1ns/1ps
package eth_txc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND_CTRL,
        STREAM,
        DRAIN
    } state_t;

    localparam logic [31:0] TXC_FLAG_NORMAL = 32'hA000_0000;

    localparam logic [1:0] CSUM_OFF     = 2'd0;
    localparam logic [1:0] CSUM_PARTIAL = 2'd1;
    localparam logic [1:0] CSUM_FULL    = 2'd2;

    function automatic logic [31:0] txc_word(
        input logic [3:0]  idx,
        input logic [1:0]  mode,
        input logic [15:0] start,
        input logic [15:0] insert,
        input logic [15:0] init
    );
        logic [31:0] w;
        case (idx)
            4'd0:    w = TXC_FLAG_NORMAL;
            4'd1:    w = {30'b0, mode};
            4'd2:    w = {start, insert};
            4'd3:    w = {16'b0, init};
            default: w = 32'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered AXI-Stream slice: full throughput, one cycle latency,
// every output driven straight from a flop.
`timescale 1ns/1ps
module axis_skid_reg #(
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DATA_W-1:0]   i_s_tdata,
    input  logic [DATA_W/8-1:0] i_s_tkeep,
    input  logic                i_s_tvalid,
    input  logic                i_s_tlast,
    output logic                o_s_tready,
    output logic [DATA_W-1:0]   o_m_tdata,
    output logic [DATA_W/8-1:0] o_m_tkeep,
    output logic                o_m_tvalid,
    output logic                o_m_tlast,
    input  logic                i_m_tready,
    output logic                o_busy
);

    logic [DATA_W-1:0]   r_m_data,  r_sk_data;
    logic [DATA_W/8-1:0] r_m_keep,  r_sk_keep;
    logic                r_m_last,  r_sk_last;
    logic                r_m_valid, r_sk_valid;
    logic                r_s_ready;

    logic w_s_hs;
    logic w_m_adv;
    logic w_sk_nxt;

    assign w_s_hs   = i_s_tvalid && r_s_ready;
    assign w_m_adv  = !r_m_valid || i_m_tready;
    assign w_sk_nxt = w_m_adv ? 1'b0 : (r_sk_valid || w_s_hs);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m_valid  <= 1'b0;
            r_sk_valid <= 1'b0;
            r_s_ready  <= 1'b0;
        end else begin
            if (w_m_adv) begin
                r_m_valid <= r_sk_valid || w_s_hs;
            end
            r_sk_valid <= w_sk_nxt;
            // ready falls the cycle after the skid entry fills
            r_s_ready  <= !w_sk_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_m_adv) begin
            if (r_sk_valid) begin
                r_m_data <= r_sk_data;
                r_m_keep <= r_sk_keep;
                r_m_last <= r_sk_last;
            end else if (w_s_hs) begin
                r_m_data <= i_s_tdata;
                r_m_keep <= i_s_tkeep;
                r_m_last <= i_s_tlast;
            end
        end else if (w_s_hs) begin
            r_sk_data <= i_s_tdata;
            r_sk_keep <= i_s_tkeep;
            r_sk_last <= i_s_tlast;
        end
    end

    assign o_s_tready = r_s_ready;
    assign o_m_tdata  = r_m_data;
    assign o_m_tkeep  = r_m_keep;
    assign o_m_tvalid = r_m_valid;
    assign o_m_tlast  = r_m_last;
    assign o_busy     = r_m_valid || r_sk_valid;

endmodule

// File: rtl/eth_txc_framer.sv
// Prefixes each TX frame with a TXC_WORDS control stream, then forwards it.
// Define ETH_TXC_CSUM_EN to carry checksum-offload fields in words 1..3.
`timescale 1ns/1ps
module eth_txc_framer
    import eth_txc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int TXC_WORDS = 6,
    parameter int CNT_W     = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [1:0]          cfg_csum_mode,
    input  logic [15:0]         cfg_csum_start,
    input  logic [15:0]         cfg_csum_insert,
    input  logic [15:0]         cfg_csum_init,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic [31:0]         m_axis_txc_data,
    output logic [3:0]          m_axis_txc_keep,
    output logic                m_axis_txc_valid,
    output logic                m_axis_txc_last,
    input  logic                m_axis_txc_ready,
    output logic [CNT_W-1:0]    frame_count,
    output logic                busy
);

    localparam logic [3:0] LAST_IDX = 4'(TXC_WORDS - 1);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_frame_cnt;

    logic w_txc_hs, w_txc_end, w_src_hs, w_m_end;
    logic w_skid_rdy, w_skid_busy, w_skid_vin;
    logic w_m_tvalid, w_m_tlast;
    logic [1:0]  w_mode;
    logic [15:0] w_start, w_insert, w_init;

`ifdef ETH_TXC_CSUM_EN
    logic [1:0]  r_mode;
    logic [15:0] r_start, r_insert, r_init;

    // shadow copy taken as the frame is announced
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_mode   <= CSUM_OFF;
            r_start  <= 16'b0;
            r_insert <= 16'b0;
            r_init   <= 16'b0;
        end else if (r_state == IDLE && s_axis_tvalid) begin
            r_mode   <= cfg_csum_mode;
            r_start  <= cfg_csum_start;
            r_insert <= cfg_csum_insert;
            r_init   <= cfg_csum_init;
        end
    end

    assign w_mode   = r_mode;
    assign w_start  = r_start;
    assign w_insert = r_insert;
    assign w_init   = r_init;
`else
    logic w_cfg_unused;
    assign w_cfg_unused = ^{cfg_csum_mode, cfg_csum_start,
                            cfg_csum_insert, cfg_csum_init};
    assign w_mode   = 2'b0;
    assign w_start  = 16'b0;
    assign w_insert = 16'b0;
    assign w_init   = 16'b0;
`endif

    assign w_txc_hs   = (r_state == SEND_CTRL) && m_axis_txc_ready;
    assign w_txc_end  = w_txc_hs && (r_idx == LAST_IDX);
    assign w_skid_vin = s_axis_tvalid && (r_state == STREAM);
    assign w_src_hs   = s_axis_tvalid && s_axis_tready;
    assign w_m_end    = w_m_tvalid && m_axis_tready && w_m_tlast;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (s_axis_tvalid) w_state_nxt = SEND_CTRL;
            SEND_CTRL: if (w_txc_end) w_state_nxt = STREAM;
            STREAM:    if (w_src_hs && s_axis_tlast) w_state_nxt = DRAIN;
            DRAIN:     if (w_m_end) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_idx       <= 4'd0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                r_idx <= 4'd0;
            end else if (w_txc_hs) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_m_end) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    axis_skid_reg #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk      (aclk),
        .i_rst      (areset),
        .i_s_tdata  (s_axis_tdata),
        .i_s_tkeep  (s_axis_tkeep),
        .i_s_tvalid (w_skid_vin),
        .i_s_tlast  (s_axis_tlast),
        .o_s_tready (w_skid_rdy),
        .o_m_tdata  (m_axis_tdata),
        .o_m_tkeep  (m_axis_tkeep),
        .o_m_tvalid (w_m_tvalid),
        .o_m_tlast  (w_m_tlast),
        .i_m_tready (m_axis_tready),
        .o_busy     (w_skid_busy)
    );

    assign s_axis_tready    = (r_state == STREAM) && w_skid_rdy;
    assign m_axis_tvalid    = w_m_tvalid;
    assign m_axis_tlast     = w_m_tlast;
    assign m_axis_txc_valid = (r_state == SEND_CTRL);
    assign m_axis_txc_data  = txc_word(r_idx, w_mode, w_start, w_insert, w_init);
    assign m_axis_txc_last  = (r_state == SEND_CTRL) && (r_idx == LAST_IDX);
    assign m_axis_txc_keep  = 4'hF;
    assign frame_count      = r_frame_cnt;
    assign busy             = (r_state != IDLE) || w_skid_busy;

endmodule

// File: tb/tb_eth_txc_framer.sv
// Directed self-checking bench for eth_txc_framer (DATA_W=32, TXC_WORDS=6).
`timescale 1ns/1ps
module tb_eth_txc_framer;

    localparam int NW = 6;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        areset;
    logic [1:0]  cfg_csum_mode;
    logic [15:0] cfg_csum_start, cfg_csum_insert, cfg_csum_init;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tready;
    logic [31:0] txc_data;
    logic [3:0]  txc_keep;
    logic        txc_valid, txc_last, txc_ready;
    logic [31:0] frame_count;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit abort = 0;
    bit src_done = 0;

    logic [1:0]  em;
    logic [15:0] es, ei, en;

    beat_t       m_q[$];
    beat_t       exp_q[$];
    logic [32:0] txc_q[$];
    int          txc_cyc[$];
    int          m_cyc[$];
    int          mlast_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_txc_framer #(
        .DATA_W    (32),
        .TXC_WORDS (NW),
        .CNT_W     (32)
    ) dut (
        .aclk             (clk),
        .areset           (areset),
        .cfg_csum_mode    (cfg_csum_mode),
        .cfg_csum_start   (cfg_csum_start),
        .cfg_csum_insert  (cfg_csum_insert),
        .cfg_csum_init    (cfg_csum_init),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tlast     (s_tlast),
        .s_axis_tready    (s_tready),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tlast     (m_tlast),
        .m_axis_tready    (m_tready),
        .m_axis_txc_data  (txc_data),
        .m_axis_txc_keep  (txc_keep),
        .m_axis_txc_valid (txc_valid),
        .m_axis_txc_last  (txc_last),
        .m_axis_txc_ready (txc_ready),
        .frame_count      (frame_count),
        .busy             (busy)
    );

    // handshakes are logged mid-cycle, ahead of the edge that completes them
    always @(negedge clk) begin
        if (!areset) begin
            if (txc_valid && txc_ready) begin
                txc_q.push_back({txc_last, txc_data});
                txc_cyc.push_back(cyc);
            end
            if (m_tvalid && m_tready) begin
                m_q.push_back({m_tlast, m_tkeep, m_tdata});
                m_cyc.push_back(cyc);
                if (m_tlast) mlast_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [31:0] exp_word(input int w);
        case (w)
            0: return 32'hA000_0000;
`ifdef ETH_TXC_CSUM_EN
            1: return {30'b0, em};
            2: return {es, ei};
            3: return {16'b0, en};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_logs();
        m_q.delete();
        exp_q.delete();
        txc_q.delete();
        txc_cyc.delete();
        m_cyc.delete();
        mlast_cyc.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
        clr_logs();
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [15:0] s,
                           input logic [15:0] i, input logic [15:0] n);
        cfg_csum_mode = m; cfg_csum_start = s;
        cfg_csum_insert = i; cfg_csum_init = n;
        em = m; es = s; ei = i; en = n;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base);
        bit hs;
        int t;
        for (int i = 0; i < n; i++) begin
            s_tdata  = base + i;
            s_tkeep  = (i == n - 1) ? 4'h7 : 4'hF;
            s_tlast  = (i == n - 1);
            s_tvalid = 1'b1;
            hs = 0;
            t = 0;
            while (!hs && !abort) begin
                @(negedge clk);
                hs = s_tready;
                if (hs) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
                @(posedge clk);
                #1;
                t++;
                if (t > 2000) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL src_timeout: beat %0d never accepted", i);
                    abort = 1;
                end
            end
            if (abort) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_fc(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && frame_count !== target; i++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, frame_count, target);
    endtask

    task automatic check_ctrl(input string tag, input int f);
        logic [32:0] v;
        for (int w = 0; w < NW; w++) begin
            v = (f * NW + w < txc_q.size()) ? txc_q[f * NW + w] : 'x;
            chk(tag, v, {w == NW - 1, exp_word(w)});
        end
    endtask

    task automatic check_data(input string tag);
        beat_t v;
        chk({tag, "_n"}, m_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            v = (k < m_q.size()) ? m_q[k] : 'x;
            chk(tag, v, exp_q[k]);
        end
    endtask

    initial begin
        int k;
        areset = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b1;
        txc_ready = 1'b1;
        set_cfg(2'd2, 16'd14, 16'd40, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txc_valid", txc_valid, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_busy", busy, 0);
        chk("txc_keep", txc_keep, 4'hF);
        areset = 1'b0;
        clr_logs();

        // single 4-beat frame, everything ready
        send_frame(4, 32'h1000_0000);
        wait_fc("t1_fc", 1, 100);
        check_ctrl("t1_txc", 0);
        check_data("t1_data");
        chk("t1_rate", (m_cyc.size() == 4) ? m_cyc[3] - m_cyc[0] : -1, 3);
        chk("t1_busy", busy, 0);

        // control back-pressure with a cfg change after the snapshot
        do_reset();
        set_cfg(2'd1, 16'h0022, 16'h0030, 16'hBEEF);
        fork
            send_frame(4, 32'h2000_0000);
            begin
                for (int i = 0; i < 50 && txc_q.size() < 2; i++) begin
                    @(posedge clk);
                    #1;
                end
                txc_ready = 1'b0;
                cfg_csum_mode = 2'd3;
                cfg_csum_init = 16'h1234;
                k = txc_q.size();
                for (int i = 0; i < 3; i++) begin
                    chk("t2_hold_data", txc_data, exp_word(k));
                    chk("t2_hold_valid", txc_valid, 1);
                    chk("t2_s_tready", s_tready, 0);
                    chk("t2_m_tvalid", m_tvalid, 0);
                    @(posedge clk);
                    #1;
                end
                txc_ready = 1'b1;
            end
        join
        wait_fc("t2_fc", 1, 100);
        check_ctrl("t2_txc", 0);
        check_data("t2_data");
        chk("t2_order", (m_cyc.size() > 0 && txc_cyc.size() == NW) ?
            (m_cyc[0] > txc_cyc[NW - 1]) : 0, 1);

        // 64-beat frame with random MAC back-pressure
        do_reset();
        set_cfg(2'd2, 16'd14, 16'd40, 16'd0);
        src_done = 0;
        fork
            begin
                send_frame(64, 32'h3000_0000);
                src_done = 1;
            end
            begin
                while (!src_done) begin
                    m_tready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                m_tready = 1'b1;
            end
        join
        wait_fc("t3_fc", 1, 500);
        check_ctrl("t3_txc", 0);
        check_data("t3_data");

        // back-to-back frames, source valid held across the boundary
        do_reset();
        send_frame(8, 32'h4000_0000);
        send_frame(5, 32'h4100_0000);
        wait_fc("t4_fc", 2, 200);
        check_ctrl("t4_txc0", 0);
        check_ctrl("t4_txc1", 1);
        check_data("t4_data");
        chk("t4_order", (txc_cyc.size() == 2 * NW && mlast_cyc.size() > 0) ?
            (txc_cyc[NW] > mlast_cyc[0]) : 0, 1);
        chk("t4_rate", (m_cyc.size() == 13) ? m_cyc[7] - m_cyc[0] : -1, 7);

        // reset in the middle of a frame
        do_reset();
        fork
            send_frame(8, 32'h5000_0000);
            begin
                for (int i = 0; i < 100 && m_q.size() < 2; i++) begin
                    @(posedge clk);
                    #1;
                end
                areset = 1'b1;
                abort = 1;
                @(posedge clk);
                #1;
                areset = 1'b0;
                chk("t5_m_tvalid", m_tvalid, 0);
                chk("t5_txc_valid", txc_valid, 0);
                chk("t5_s_tready", s_tready, 0);
                chk("t5_fc", frame_count, 0);
                chk("t5_busy", busy, 0);
            end
        join
        abort = 0;
        @(posedge clk);
        #1;
        clr_logs();
        send_frame(4, 32'h6000_0000);
        wait_fc("t5_fc_after", 1, 100);
        check_ctrl("t5_txc", 0);
        check_data("t5_data");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
